// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO.
// Holds the write FSM state encoding and the bit layout of a stored RAM word.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  // A stored word is {sop, eop, data}. The two framing bits sit directly above the data field.
  localparam int unsigned CTRL_W = 2;

  function automatic int unsigned word_width(input int unsigned dw);
    return dw + CTRL_W;
  endfunction

  function automatic int unsigned eop_pos(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned sop_pos(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with one write port and one synchronous read port.
// The read data register holds its value on cycles where no read is issued.
module sdp_ram #(
  parameter int unsigned WW = 18,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward packet FIFO: packets become readable only once their eop is written;
// over-length, overflowing or malformed packets are discarded whole and counted.
module pkt_fifo_sf
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic [DW-1:0] din,
  input  logic          dout_rdy,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] drop_cnt,
  output logic [AW:0]   pkt_cnt
);

  localparam int unsigned WW    = word_width(DW);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned EOP_B = eop_pos(DW);
  localparam int unsigned SOP_B = sop_pos(DW);

  localparam logic [PW-1:0] DEPTH_P = PW'(1 << AW);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  wr_state_e     state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] cmt_ptr, cmt_ptr_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] base_ptr;
  logic          wr_en;
  logic          commit;
  logic [1:0]    drop_amt;

  logic          pf_vld;
  logic          rd_avail;
  logic          rd_issue;
  logic          out_take;
  logic          pkt_dec;
  logic [WW-1:0] ram_wdata;
  logic [WW-1:0] ram_rdata;
  logic [CW:0]   drop_sum;

  // Write FSM: base_ptr is where an incoming word lands; a restarting sop in W_PKT
  // rewinds to the commit pointer and may also overflow, hence up to two drops per cycle.
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    base_ptr    = wr_ptr;
    wr_en       = 1'b0;
    commit      = 1'b0;
    drop_amt    = 2'd0;

    if (din_vld) begin
      if (din_sop) begin
        if (state == W_PKT) begin
          base_ptr   = cmt_ptr;
          wr_ptr_nxt = cmt_ptr;
          drop_amt   = 2'd1;
        end
        if ((base_ptr - rd_ptr) != DEPTH_P) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = base_ptr + ONE_P;
          if (din_eop) begin
            cmt_ptr_nxt = base_ptr + ONE_P;
            commit      = 1'b1;
            state_nxt   = W_IDLE;
          end else begin
            state_nxt = W_PKT;
          end
        end else begin
          drop_amt  = drop_amt + 2'd1;
          state_nxt = din_eop ? W_IDLE : W_DROP;
        end
      end else begin
        case (state)
          W_PKT: begin
            if ((wr_ptr - rd_ptr) != DEPTH_P) begin
              wr_en      = 1'b1;
              wr_ptr_nxt = wr_ptr + ONE_P;
              if (din_eop) begin
                cmt_ptr_nxt = wr_ptr + ONE_P;
                commit      = 1'b1;
                state_nxt   = W_IDLE;
              end
            end else begin
              wr_ptr_nxt = cmt_ptr;
              drop_amt   = 2'd1;
              state_nxt  = din_eop ? W_IDLE : W_DROP;
            end
          end
          W_DROP: begin
            if (din_eop) begin
              state_nxt = W_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= W_IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      cmt_ptr <= cmt_ptr_nxt;
    end
  end

  assign ram_wdata = {din_sop, din_eop, din};

  sdp_ram #(
    .WW (WW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (base_ptr[AW-1:0]),
    .wdata (ram_wdata),
    .re    (rd_issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Read pipeline: RAM read register acts as a one-word prefetch feeding the output register.
  assign rd_avail = (rd_ptr != cmt_ptr);
  assign out_take = pf_vld && (!dout_vld || dout_rdy);
  assign rd_issue = rd_avail && (!pf_vld || out_take);
  assign pkt_dec  = dout_vld && dout_rdy && dout_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      pf_vld <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      if (rd_issue) begin
        pf_vld <= 1'b1;
      end else if (out_take) begin
        pf_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout     <= '0;
    end else if (out_take) begin
      dout_vld <= 1'b1;
      dout_sop <= ram_rdata[SOP_B];
      dout_eop <= ram_rdata[EOP_B];
      dout     <= ram_rdata[DW-1:0];
    end else if (dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

  // Counters: drop count saturates, packet count tracks committed-but-unread packets.
  assign drop_sum = {1'b0, drop_cnt} + (CW + 1)'(drop_amt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (drop_sum[CW]) begin
        drop_cnt <= '1;
      end else begin
        drop_cnt <= drop_sum[CW-1:0];
      end
      case ({commit, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule
